// File: rtl/raster_frame_walker.sv
// Walks instances and their triangles, fetching indices and vertices from 1-cycle RAMs
// and emitting one assembled triangle per valid/ready beat.
module raster_frame_walker #(
  parameter int MAX_VERT     = 8192,
  parameter int MAX_TRI      = 8192,
  parameter int MAX_INST     = 256,
  parameter int MAX_VERT_CNT = 256,
  parameter int MAX_TRI_CNT  = 256,
  parameter int VTX_W        = 108,
  parameter int TRANS_W      = 288,
  parameter int VERT_ADDR_W  = $clog2(MAX_VERT),
  parameter int TRI_ADDR_W   = $clog2(MAX_TRI),
  parameter int INST_W       = $clog2(MAX_INST),
  parameter int VIDX_W       = $clog2(MAX_VERT_CNT),
  parameter int TIDX_W       = $clog2(MAX_TRI_CNT)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   frame_start,
  input  logic [INST_W:0]        num_inst,
  output logic [INST_W-1:0]      inst_id_rd,
  output logic [VERT_ADDR_W-1:0] vert_addr_rd,
  output logic [TRI_ADDR_W-1:0]  tri_addr_rd,
  input  logic [VERT_ADDR_W-1:0] vert_base_in,
  input  logic [VIDX_W-1:0]      vert_count_in,
  input  logic [TRI_ADDR_W-1:0]  tri_base_in,
  input  logic [TIDX_W-1:0]      tri_count_in,
  input  logic [3*VIDX_W-1:0]    idx_tri_in,
  input  logic [VTX_W-1:0]       vert_in,
  input  logic [TRANS_W-1:0]     transform_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [VTX_W-1:0]       out_v0,
  output logic [VTX_W-1:0]       out_v1,
  output logic [VTX_W-1:0]       out_v2,
  output logic [TRANS_W-1:0]     out_transform,
  output logic [INST_W-1:0]      out_inst_id,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   idx_err
);

  typedef enum logic [3:0] {
    S_IDLE, S_INST_SEL, S_INST_LAT, S_TRI_RD, S_TRI_LAT, S_V_RD, S_V_LAT, S_EMIT, S_DONE
  } state_t;

  state_t                 state, state_nxt;
  logic [INST_W:0]        num_lat;
  logic [VERT_ADDR_W-1:0] vert_base;
  logic [VIDX_W-1:0]      vert_cnt;
  logic [TRI_ADDR_W-1:0]  tri_base;
  logic [TIDX_W-1:0]      tri_cnt;
  logic [TIDX_W-1:0]      tri_ctr;
  logic [3*VIDX_W-1:0]    idx_lat;
  logic [1:0]             k;

  logic [INST_W:0]        inst_nxt;
  logic [TIDX_W:0]        tri_nxt;
  logic                   more_inst;
  logic                   more_tri;
  logic                   idx_bad;
  logic [VIDX_W-1:0]      vidx_nxt;

  // inst_id_rd doubles as the instance counter; it only advances while instances remain
  assign inst_nxt  = {1'b0, inst_id_rd} + (INST_W+1)'(1);
  assign tri_nxt   = {1'b0, tri_ctr} + (TIDX_W+1)'(1);
  assign more_inst = inst_nxt < num_lat;
  assign more_tri  = tri_nxt < {1'b0, tri_cnt};
  assign idx_bad   = (idx_tri_in[VIDX_W-1:0] >= vert_cnt) ||
                     (idx_tri_in[2*VIDX_W-1:VIDX_W] >= vert_cnt) ||
                     (idx_tri_in[3*VIDX_W-1:2*VIDX_W] >= vert_cnt);
  assign vidx_nxt  = (k == 2'd0) ? idx_lat[2*VIDX_W-1:VIDX_W] : idx_lat[3*VIDX_W-1:2*VIDX_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    out_valid  = 1'b0;
    frame_done = 1'b0;
    case (state)
      S_IDLE:     if (frame_start) state_nxt = (num_inst == '0) ? S_DONE : S_INST_SEL;
      S_INST_SEL: state_nxt = S_INST_LAT;
      S_INST_LAT: begin
        if (tri_count_in != '0) state_nxt = S_TRI_RD;
        else                    state_nxt = more_inst ? S_INST_SEL : S_DONE;
      end
      S_TRI_RD:   state_nxt = S_TRI_LAT;
      S_TRI_LAT:  state_nxt = S_V_RD;
      S_V_RD:     state_nxt = S_V_LAT;
      S_V_LAT:    state_nxt = (k == 2'd2) ? S_EMIT : S_V_RD;
      S_EMIT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (more_tri)       state_nxt = S_TRI_RD;
          else if (more_inst) state_nxt = S_INST_SEL;
          else                state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        frame_done = 1'b1;
        state_nxt  = S_IDLE;
      end
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_lat       <= '0;
      inst_id_rd    <= '0;
      vert_addr_rd  <= '0;
      tri_addr_rd   <= '0;
      vert_base     <= '0;
      vert_cnt      <= '0;
      tri_base      <= '0;
      tri_cnt       <= '0;
      tri_ctr       <= '0;
      idx_lat       <= '0;
      k             <= '0;
      out_v0        <= '0;
      out_v1        <= '0;
      out_v2        <= '0;
      out_transform <= '0;
      out_inst_id   <= '0;
      busy          <= 1'b0;
      idx_err       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (frame_start && (num_inst != '0)) begin
            num_lat    <= num_inst;
            inst_id_rd <= '0;
            idx_err    <= 1'b0;
            busy       <= 1'b1;
          end
        end
        S_INST_LAT: begin
          vert_base     <= vert_base_in;
          vert_cnt      <= vert_count_in;
          tri_base      <= tri_base_in;
          tri_cnt       <= tri_count_in;
          out_transform <= transform_in;
          out_inst_id   <= inst_id_rd;
          tri_ctr       <= '0;
          tri_addr_rd   <= tri_base_in;
          if ((tri_count_in == '0) && more_inst) inst_id_rd <= inst_nxt[INST_W-1:0];
        end
        S_TRI_LAT: begin
          idx_lat      <= idx_tri_in;
          k            <= 2'd0;
          vert_addr_rd <= vert_base + VERT_ADDR_W'(idx_tri_in[VIDX_W-1:0]);
          if (idx_bad) idx_err <= 1'b1;
        end
        S_V_LAT: begin
          case (k)
            2'd0:    out_v0 <= vert_in;
            2'd1:    out_v1 <= vert_in;
            default: out_v2 <= vert_in;
          endcase
          if (k != 2'd2) begin
            k            <= k + 2'd1;
            vert_addr_rd <= vert_base + VERT_ADDR_W'(vidx_nxt);
          end
        end
        S_EMIT: begin
          if (out_ready) begin
            tri_ctr <= tri_nxt[TIDX_W-1:0];
            if (more_tri)       tri_addr_rd <= tri_base + TRI_ADDR_W'(tri_nxt);
            else if (more_inst) inst_id_rd  <= inst_nxt[INST_W-1:0];
          end
        end
        S_DONE:  busy <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_raster_frame_walker.sv
// Randomized bench for raster_frame_walker: RAM/descriptor models plus a frame-level
// reference that lists the expected triangle beats, idx_err and walk length.
module tb_raster_frame_walker;
  localparam int MAX_VERT = 8192;
  localparam int MAX_TRI  = 8192;
  localparam int MAX_INST = 256;
  localparam int VA = 13, TA = 13, IW = 8, VW = 8, TW = 8;
  localparam int VTX_W = 108, TRANS_W = 288;

  typedef struct packed {
    logic [VTX_W-1:0]   v0;
    logic [VTX_W-1:0]   v1;
    logic [VTX_W-1:0]   v2;
    logic [TRANS_W-1:0] xf;
    logic [IW-1:0]      id;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n, frame_start, out_ready, out_valid, busy, frame_done, idx_err;
  logic [IW:0]         num_inst;
  logic [IW-1:0]       inst_id_rd, out_inst_id;
  logic [VA-1:0]       vert_addr_rd, vert_base_in;
  logic [TA-1:0]       tri_addr_rd, tri_base_in;
  logic [VW-1:0]       vert_count_in;
  logic [TW-1:0]       tri_count_in;
  logic [3*VW-1:0]     idx_tri_in;
  logic [VTX_W-1:0]    vert_in, out_v0, out_v1, out_v2;
  logic [TRANS_W-1:0]  transform_in, out_transform;

  always #5 clk = ~clk;

  raster_frame_walker dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .num_inst(num_inst),
    .inst_id_rd(inst_id_rd), .vert_addr_rd(vert_addr_rd), .tri_addr_rd(tri_addr_rd),
    .vert_base_in(vert_base_in), .vert_count_in(vert_count_in), .tri_base_in(tri_base_in),
    .tri_count_in(tri_count_in), .idx_tri_in(idx_tri_in), .vert_in(vert_in),
    .transform_in(transform_in), .out_valid(out_valid), .out_ready(out_ready),
    .out_v0(out_v0), .out_v1(out_v1), .out_v2(out_v2), .out_transform(out_transform),
    .out_inst_id(out_inst_id), .busy(busy), .frame_done(frame_done), .idx_err(idx_err)
  );

  logic [VTX_W-1:0]   vram [MAX_VERT];
  logic [3*VW-1:0]    tram [MAX_TRI];
  logic [TRANS_W-1:0] xram [MAX_INST];
  logic [VA-1:0]      d_vb [MAX_INST];
  logic [VW-1:0]      d_vc [MAX_INST];
  logic [TA-1:0]      d_tb [MAX_INST];
  logic [TW-1:0]      d_tc [MAX_INST];

  assign vert_base_in  = d_vb[inst_id_rd];
  assign vert_count_in = d_vc[inst_id_rd];
  assign tri_base_in   = d_tb[inst_id_rd];
  assign tri_count_in  = d_tc[inst_id_rd];

  always @(posedge clk) begin
    vert_in      <= vram[vert_addr_rd];
    idx_tri_in   <= tram[tri_addr_rd];
    transform_in <= xram[inst_id_rd];
  end

  int checks = 0;
  int errors = 0;
  beat_t obs_q[$];
  beat_t exp_q[$];
  logic [VA-1:0] va_q[$];
  int  done_cyc, first_vld, unstable, exp_cyc;
  bit  busy_seen, vld_seen, timed_out, err_at_done, exp_err;

  function automatic logic [VTX_W-1:0] rand_vtx();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[VTX_W-1:0];
  endfunction

  function automatic logic [TRANS_W-1:0] rand_xf();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic init_mem();
    for (int i = 0; i < MAX_VERT; i++) vram[i] = rand_vtx();
    for (int i = 0; i < MAX_TRI; i++) tram[i] = (3*VW)'($urandom);
    for (int i = 0; i < MAX_INST; i++) begin
      xram[i] = rand_xf();
      d_vb[i] = '0; d_vc[i] = '0; d_tb[i] = '0; d_tc[i] = '0;
    end
  endtask

  task automatic rand_inst(input int i, input int min_tc, input int max_tc, input bit allow_err);
    logic [3*VW-1:0] w;
    d_vb[i] = VA'($urandom_range(0, MAX_VERT-1));
    d_vc[i] = VW'($urandom_range(1, 255));
    d_tb[i] = TA'($urandom_range(0, MAX_TRI-1));
    d_tc[i] = TW'($urandom_range(min_tc, max_tc));
    for (int t = 0; t < int'(d_tc[i]); t++) begin
      for (int k = 0; k < 3; k++) begin
        if (allow_err && ($urandom_range(0, 3) == 0)) w[k*VW +: VW] = VW'($urandom_range(0, 255));
        else w[k*VW +: VW] = VW'($urandom_range(0, int'(d_vc[i]) - 1));
      end
      tram[(int'(d_tb[i]) + t) % MAX_TRI] = w;
    end
  endtask

  // Reference: expected beats in walk order, sticky error, and walk length at full rate.
  task automatic model_frame(input int n);
    exp_q.delete();
    exp_err = 0;
    exp_cyc = 1;
    for (int i = 0; i < n; i++) begin
      exp_cyc += 2 + 9 * int'(d_tc[i]);
      for (int t = 0; t < int'(d_tc[i]); t++) begin
        logic [3*VW-1:0] w;
        logic [VTX_W-1:0] v [3];
        beat_t b;
        w = tram[(int'(d_tb[i]) + t) % MAX_TRI];
        for (int k = 0; k < 3; k++) begin
          int idx;
          idx = int'(w[k*VW +: VW]);
          if (idx >= int'(d_vc[i])) exp_err = 1;
          v[k] = vram[(int'(d_vb[i]) + idx) % MAX_VERT];
        end
        b = {v[0], v[1], v[2], xram[i], IW'(i)};
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; frame_start = 1'b0; out_ready = 1'b0; num_inst = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Drives one frame and records what the DUT did; cycle 1 is the cycle after frame_start.
  task automatic run_walk(input int n, input bit rnd_ready, input int stall_beat,
                          input int stall_len, input int restart_cyc, input int budget);
    int cyc, stall_left, nbeat;
    bit done, holding, stalled;
    beat_t cur, held;
    logic [VA-1:0] last_va;
    obs_q.delete(); va_q.delete();
    done_cyc = -1; first_vld = -1; unstable = 0;
    busy_seen = 0; vld_seen = 0; timed_out = 0; err_at_done = 0;
    cyc = 0; stall_left = 0; nbeat = 0; done = 0; holding = 0; stalled = 0;
    held = '0;
    last_va = vert_addr_rd;
    @(posedge clk); #1;
    num_inst = (IW+1)'(n); frame_start = 1'b1; out_ready = 1'b1;
    while (!done && cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
      frame_start = (cyc == restart_cyc);
      if (frame_start) num_inst = (IW+1)'($urandom_range(1, 4));
      if (out_valid && nbeat == stall_beat && !stalled) begin
        stalled = 1; stall_left = stall_len;
      end
      if (stall_left > 0) begin out_ready = 1'b0; stall_left--; end
      else out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (busy) busy_seen = 1;
      if (vert_addr_rd !== last_va) begin va_q.push_back(vert_addr_rd); last_va = vert_addr_rd; end
      if (out_valid) begin
        cur = {out_v0, out_v1, out_v2, out_transform, out_inst_id};
        vld_seen = 1;
        if (first_vld < 0) first_vld = cyc;
        if (holding && cur !== held) unstable++;
        if (out_ready) begin obs_q.push_back(cur); nbeat++; holding = 0; end
        else begin holding = 1; held = cur; end
      end else if (holding) begin
        unstable++; holding = 0;
      end
      if (frame_done) begin done = 1; done_cyc = cyc; err_at_done = idx_err; end
    end
    frame_start = 1'b0;
    out_ready = 1'b0;
    if (!done) timed_out = 1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; frame_start = 1'b0; out_ready = 1'b0; num_inst = '0;
    @(negedge clk);
    checks++;
    if ({out_valid, busy, frame_done, idx_err} !== 4'b0) begin
      errors++; $display("FAIL reset_in_flags got %b exp 0000", {out_valid, busy, frame_done, idx_err});
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({out_valid, busy, frame_done, idx_err} !== 4'b0) begin
      errors++; $display("FAIL reset_flags got %b exp 0000", {out_valid, busy, frame_done, idx_err});
    end
    checks++;
    if ({inst_id_rd, vert_addr_rd, tri_addr_rd} !== '0) begin
      errors++; $display("FAIL reset_addr got %h/%h/%h exp 0", inst_id_rd, vert_addr_rd, tri_addr_rd);
    end
    checks++;
    if ({out_v0, out_v1, out_v2, out_transform, out_inst_id} !== '0) begin
      errors++; $display("FAIL reset_data got nonzero out_* data exp 0");
    end
  endtask

  task automatic test_zero_inst();
    run_walk(0, 0, -1, 0, -1, 50);
    checks++;
    if (timed_out || done_cyc != 1) begin
      errors++; $display("FAIL zero_done_cycle got %0d exp 1", done_cyc);
    end
    checks++;
    if (busy_seen || vld_seen) begin
      errors++; $display("FAIL zero_quiet got busy=%0b valid=%0b exp 0/0", busy_seen, vld_seen);
    end
  endtask

  task automatic test_single_tri();
    do_reset();
    d_vb[0] = VA'(100); d_vc[0] = VW'(200); d_tb[0] = TA'(40); d_tc[0] = TW'(1);
    tram[40] = {8'd2, 8'd1, 8'd0};
    model_frame(1);
    run_walk(1, 0, -1, 0, -1, 100);
    checks++;
    if (first_vld != 11) begin
      errors++; $display("FAIL single_first_valid got %0d exp 11", first_vld);
    end
    checks++;
    if (obs_q.size() != 1 || obs_q[0].v0 !== vram[100] || obs_q[0].v1 !== vram[101] ||
        obs_q[0].v2 !== vram[102]) begin
      errors++; $display("FAIL single_vertices got %0d beats exp 1 with RAM[100..102]", obs_q.size());
    end
    checks++;
    if (obs_q.size() != 1 || obs_q[0].id !== 8'd0 || obs_q[0].xf !== xram[0]) begin
      errors++; $display("FAIL single_id_xf got id %0d exp 0 / transform of inst0", obs_q[0].id);
    end
    checks++;
    if (timed_out || done_cyc != 12) begin
      errors++; $display("FAIL single_done_cycle got %0d exp 12", done_cyc);
    end
  endtask

  task automatic test_multi_inst();
    logic [IW-1:0] ids [4];
    ids = '{8'd0, 8'd0, 8'd2, 8'd2};
    rand_inst(0, 2, 2, 0);
    rand_inst(1, 0, 0, 0);
    rand_inst(2, 2, 2, 0);
    model_frame(3);
    run_walk(3, 0, -1, 0, -1, 200);
    checks++;
    if (timed_out || done_cyc != exp_cyc) begin
      errors++; $display("FAIL multi_done_cycle got %0d exp %0d", done_cyc, exp_cyc);
    end
    checks++;
    if (obs_q.size() != 4) begin
      errors++; $display("FAIL multi_beat_count got %0d exp 4", obs_q.size());
    end
    for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i] || obs_q[i].id !== ids[i]) begin
        errors++; $display("FAIL multi_beat%0d got id %0d %h exp id %0d %h", i, obs_q[i].id,
                           obs_q[i].v0, ids[i], exp_q[i].v0);
      end
    end
  endtask

  task automatic test_backpressure();
    rand_inst(0, 2, 2, 0);
    model_frame(1);
    run_walk(1, 0, 0, 20, -1, 200);
    checks++;
    if (unstable != 0) begin
      errors++; $display("FAIL bp_stable got %0d changes exp 0", unstable);
    end
    checks++;
    if (obs_q.size() != 2 || obs_q[0] !== exp_q[0] || obs_q[1] !== exp_q[1]) begin
      errors++; $display("FAIL bp_beats got %0d beats exp 2 matching model", obs_q.size());
    end
    checks++;
    if (timed_out || done_cyc != exp_cyc + 20) begin
      errors++; $display("FAIL bp_done_cycle got %0d exp %0d", done_cyc, exp_cyc + 20);
    end
  endtask

  task automatic test_idx_err_wrap();
    do_reset();
    d_vb[0] = VA'(8190); d_vc[0] = VW'(5); d_tb[0] = TA'($urandom_range(0, MAX_TRI-1)); d_tc[0] = TW'(1);
    tram[d_tb[0]] = {8'd7, 8'd3, 8'd1};
    model_frame(1);
    run_walk(1, 0, -1, 0, -1, 100);
    checks++;
    if (timed_out || err_at_done !== 1'b1) begin
      errors++; $display("FAIL err_flag got %0b exp 1", err_at_done);
    end
    checks++;
    if (obs_q.size() != 1 || obs_q[0].v0 !== vram[8191] || obs_q[0].v1 !== vram[1] ||
        obs_q[0].v2 !== vram[5]) begin
      errors++; $display("FAIL err_wrap_beat got %0d beats exp 1 with RAM[8191,1,5]", obs_q.size());
    end
    checks++;
    if (va_q.size() != 3 || va_q[0] !== 13'd8191 || va_q[1] !== 13'd1 || va_q[2] !== 13'd5) begin
      errors++; $display("FAIL wrap_addr got %0d addrs first %0d/%0d exp 8191,1,5", va_q.size(),
                         va_q[0], va_q[1]);
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 6; f++) begin
      int n;
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) rand_inst(i, 0, 3, 1);
      model_frame(n);
      run_walk(n, 1, -1, 0, -1, 3000);
      checks++;
      if (timed_out || unstable != 0 || obs_q.size() != exp_q.size()) begin
        errors++; $display("FAIL rand%0d_shape got beats %0d unstable %0d exp beats %0d", f,
                           obs_q.size(), unstable, exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL rand%0d_beat%0d got id %0d %h exp id %0d %h", f, i,
                             obs_q[i].id, obs_q[i].v2, exp_q[i].id, exp_q[i].v2);
        end
      end
      checks++;
      if (err_at_done !== exp_err) begin
        errors++; $display("FAIL rand%0d_idx_err got %0b exp %0b", f, err_at_done, exp_err);
      end
    end
  endtask

  task automatic test_abort_restart();
    logic [3*VW-1:0] w;
    bit seen;
    do_reset();
    rand_inst(0, 2, 2, 0);
    w = tram[d_tb[0]];
    w[VW-1:0] = d_vc[0];
    tram[d_tb[0]] = w;
    @(posedge clk); #1;
    num_inst = (IW+1)'(1); frame_start = 1'b1; out_ready = 1'b1;
    for (int c = 1; c <= 6; c++) begin @(posedge clk); #1 frame_start = 1'b0; end
    checks++;
    if (idx_err !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL abort_pre got err=%0b busy=%0b exp 1/1", idx_err, busy);
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid, busy, frame_done, idx_err} !== 4'b0 ||
        {inst_id_rd, vert_addr_rd, tri_addr_rd} !== '0) begin
      errors++; $display("FAIL abort_outputs got flags %b addr %h exp 0", {out_valid, busy, frame_done, idx_err},
                         vert_addr_rd);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    seen = 0;
    repeat (15) begin @(negedge clk); if (busy || frame_done || out_valid) seen = 1; end
    checks++;
    if (seen) begin
      errors++; $display("FAIL abort_idle got activity=1 exp 0");
    end
    rand_inst(0, 1, 3, 0);
    model_frame(1);
    run_walk(1, 0, -1, 0, 5, 500);
    checks++;
    if (timed_out || done_cyc != exp_cyc || obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL restart_ignored got done %0d beats %0d exp %0d/%0d", done_cyc,
                         obs_q.size(), exp_cyc, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL restart_beat%0d got %h exp %h", i, obs_q[i].v0, exp_q[i].v0);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; frame_start = 1'b0; out_ready = 1'b0; num_inst = '0;
    init_mem();
    test_reset();
    test_zero_inst();
    test_single_tri();
    test_multi_inst();
    test_backpressure();
    test_idx_err_wrap();
    test_random();
    test_abort_restart();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
